// File: rtl/date_to_doy_pkg.sv
// Calendar helpers shared by the date-to-day-of-year converter:
// BCD digit type, FSM state encoding and month-length lookup.
package cal_pkg;
  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {IDLE, CHECK, ACCUM} state_t;

  localparam logic [3:0] MAX_MONTH = 4'd12;

  // Two-digit BCD month lengths for a common year, January first
  localparam logic [7:0] MONTH_LEN [12] = '{
    8'h31, 8'h28, 8'h31, 8'h30, 8'h31, 8'h30,
    8'h31, 8'h31, 8'h30, 8'h31, 8'h30, 8'h31
  };

  function automatic logic [7:0] days_in_month(input logic [3:0] month, input logic leap);
    logic [7:0] len;
    len = 8'h00;
    if (month >= 4'd1 && month <= MAX_MONTH)
      len = MONTH_LEN[month - 4'd1];
    if (month == 4'd2 && leap)
      len = 8'h29;
    return len;
  endfunction
endpackage

// File: rtl/date_to_doy_bcd_digit_adder.sv
// Single BCD digit adder: a + b + cin with decimal carry-out.
module bcd_digit_adder
  import cal_pkg::*;
(
  input  bcd_t a,
  input  bcd_t b,
  input  logic cin,
  output bcd_t sum,
  output logic cout
);
  logic [4:0] w_raw;
  logic [3:0] w_adj;

  always_comb begin
    w_raw = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    // Adding 6 modulo 16 is the same as subtracting 10 from the low nibble
    w_adj = w_raw[3:0] + 4'd6;
    cout  = (w_raw > 5'd9);
    sum   = cout ? w_adj : w_raw[3:0];
  end
endmodule

// File: rtl/date_to_doy.sv
// Iterative month/day to BCD day-of-year converter with start/done handshake.
// Optional binary day-of-year output enabled by DOY_BIN_OUT_EN.
module date_to_doy
  import cal_pkg::*;
#(
  parameter logic [11:0] DEFAULT_DOY = 12'h001
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] month,
  input  logic [3:0] d10,
  input  logic [3:0] d1,
  input  logic       leap,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] doy_h,
  output logic [3:0] doy_t,
`ifdef DOY_BIN_OUT_EN
  output logic [3:0] doy_o,
  output logic [8:0] doy_bin
`else
  output logic [3:0] doy_o
`endif
);
  state_t      r_state, w_next;
  logic [3:0]  r_month, r_d10, r_d1, r_m;
  logic        r_leap, r_done, r_err;
  logic [11:0] r_acc, r_doy, w_sum;
  logic [7:0]  w_len;
  logic        w_illegal, w_last, w_c1, w_c2, w_carry_unused;

  assign w_len  = days_in_month(r_m, r_leap);
  assign w_last = (r_m == r_month);

  always_comb begin
    w_illegal = (r_month == 4'd0) || (r_month > MAX_MONTH) ||
                (r_d10 > 4'd9) || (r_d1 > 4'd9) ||
                ({r_d10, r_d1} == 8'h00) ||
                ({r_d10, r_d1} > days_in_month(r_month, r_leap));
  end

  // Accumulator ripple chain: 3-digit acc + 2-digit month length
  bcd_digit_adder u_add_o (.a(r_acc[3:0]),  .b(w_len[3:0]), .cin(1'b0), .sum(w_sum[3:0]),  .cout(w_c1));
  bcd_digit_adder u_add_t (.a(r_acc[7:4]),  .b(w_len[7:4]), .cin(w_c1), .sum(w_sum[7:4]),  .cout(w_c2));
  bcd_digit_adder u_add_h (.a(r_acc[11:8]), .b(4'h0),       .cin(w_c2), .sum(w_sum[11:8]), .cout(w_carry_unused));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = CHECK;
      CHECK:   w_next = w_illegal ? IDLE : ACCUM;
      ACCUM:   if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = (r_state != IDLE);
    done  = r_done;
    err   = r_err;
    doy_h = r_doy[11:8];
    doy_t = r_doy[7:4];
    doy_o = r_doy[3:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_month <= '0;
      r_d10   <= '0;
      r_d1    <= '0;
      r_leap  <= 1'b0;
      r_m     <= '0;
      r_acc   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_doy   <= DEFAULT_DOY;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_month <= month;
          r_d10   <= d10;
          r_d1    <= d1;
          r_leap  <= leap;
        end
        CHECK: if (w_illegal) begin
          r_done <= 1'b1;
          r_err  <= 1'b1;
          r_doy  <= 12'h000;
        end else begin
          r_acc <= {4'h0, r_d10, r_d1};
          r_m   <= 4'd1;
        end
        ACCUM: if (w_last) begin
          r_doy  <= r_acc;
          r_err  <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_acc <= w_sum;
          r_m   <= r_m + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef DOY_BIN_OUT_EN
  logic [8:0] r_bin_acc, r_doy_bin, w_len_bin;

  assign w_len_bin = {5'b0, w_len[7:4]} * 9'd10 + {5'b0, w_len[3:0]};
  assign doy_bin   = r_doy_bin;

  // Binary path follows the BCD accumulator step for step
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bin_acc <= '0;
      r_doy_bin <= 9'd1;
    end else begin
      case (r_state)
        CHECK: if (w_illegal) r_doy_bin <= 9'd0;
               else r_bin_acc <= {5'b0, r_d10} * 9'd10 + {5'b0, r_d1};
        ACCUM: if (w_last) r_doy_bin <= r_bin_acc;
               else r_bin_acc <= r_bin_acc + w_len_bin;
        default: ;
      endcase
    end
  end
`endif
endmodule

// File: doc/date_to_doy.md
Name: date_to_doy

Overview:
- Iterative converter from calendar date to day-of-year. It is the inverse of the day-counter-to-month/day decoder.
- Accepts month plus BCD day and a leap flag. Produces a 3-digit BCD day-of-year (001..366) with start/done handshake.
- Sits between the date-entry switches and the day counter, so a user-entered date can preload the counter.

Parameters:
- DEFAULT_DOY, 12'h001, BCD day-of-year driven on outputs at reset (Jan 1).

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only when busy=0
- month  in  4  binary month, 1..12 legal
- d10  in  4  BCD tens of day
- d1  in  4  BCD ones of day
- leap  in  1  1 = February has 29 days
- busy  out  1  conversion in progress
- done  out  1  one-cycle completion pulse
- err  out  1  last request was an illegal date; valid with/after done
- doy_h  out  4  BCD hundreds of day-of-year
- doy_t  out  4  BCD tens
- doy_o  out  4  BCD ones

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; busy=0, done=0, err=0.
  - {doy_h,doy_t,doy_o}=DEFAULT_DOY.
  - Internal accumulator, month index and captured inputs cleared.
  - Reset mid-conversion aborts it; no done pulse is produced.
- States: IDLE, CHECK, ACCUM.
- IDLE:
  - start=1 at an edge captures month, d10, d1 and leap, then goes to CHECK with busy=1.
  - done is cleared every edge it is not being set.
- CHECK (1 edge). Illegal when any of these hold:
  - month==0 or month>12;
  - d10>9 or d1>9;
  - day==0;
  - day > days_in_month(month, leap).
- CHECK outcome:
  - Illegal: go to IDLE; done=1, err=1, busy=0; doy outputs = 000.
  - Legal: acc = {0, d10, d1}, m=1; go to ACCUM.
- ACCUM (one edge per iteration):
  - If m==month: outputs <= acc, err=0, done=1, busy=0; go to IDLE.
  - Else: acc <= acc + days_in_month(m, leap) in BCD; m <= m+1.
- Latency: counted from the start-sampling edge k.
  - Legal date: done high after edge k+1+month (Jan: k+2; Dec: k+13).
  - Illegal date: done high after edge k+1.
- Month lengths: 31,28+leap,31,30,31,30,31,31,30,31,30,31. The leap value used is the one captured at start, not the live input.
- BCD arithmetic:
  - 3-digit accumulator plus 2-digit addend, ripple per digit; a digit sum >9 subtracts 10 and carries.
  - Hundreds never exceeds 3 (max 366), so no overflow handling is needed.
- Output holding:
  - Outputs change only at completion.
  - doy and err hold until the next completion or reset.
- start while busy=1 is ignored, not queued.
- start held high: a new conversion begins on the first edge with busy=0. done and the new capture may coincide; done is still a single-cycle pulse.
- Inputs may change freely after the capture edge.

Optional Feature:
- Macro DOY_BIN_OUT_EN.
- Defined:
  - Adds output doy_bin (out, 9 bits), the binary day-of-year (1..366).
  - Accumulated in parallel with the BCD path and updated at the same completion edge.
  - Reset value is 1; 0 on err.
- Undefined: port and logic absent; BCD behaviour identical.

Decomposition:
- Package cal_pkg holds:
  - typedef bcd_t (4-bit);
  - state enum {IDLE, CHECK, ACCUM};
  - month-length constant array;
  - function days_in_month(month, leap) returning 2-digit BCD;
  - constant MAX_MONTH=12.
- One sub-module, bcd_digit_adder: combinational a + b + cin -> sum digit, cout. Instantiated 3x as the accumulator ripple chain.

Test Plan:
- Reset, then start with month=1, d=01, leap=0 -> done after edge k+2; doy=001, err=0; busy high for 2 cycles.
- month=3, d=01, leap=0 -> doy=060. Repeat with leap=1 -> doy=061.
- month=12, d=31, leap=1 -> doy=366, done after edge k+13. Toggle leap during busy -> result unchanged.
- Illegal dates (Feb 29 with leap=0, month=13, d=00, d1=4'hA) -> done after edge k+1, err=1, doy=000. A following legal request clears err.
- Assert reset_n=0 in ACCUM for month=10 -> outputs immediately DEFAULT_DOY, no done. Post-reset request month=2, d=15 -> 046.
- Pulse start again while busy -> ignored; exactly one done per accepted request. With DOY_BIN_OUT_EN defined, doy_bin matches the BCD result in all cases.
